// File: rtl/spi_pkg.sv
// Constants shared by the SPI peripheral and controller: byte size, status/control
// bit positions and the Wishbone register map offsets relative to the base address.
package spi_pkg;

    localparam int BYTE_SIZE = 8;

    localparam int STAT_FRAME_DONE = 0;
    localparam int STAT_OVERRUN    = 1;
    localparam int STAT_ABORT      = 2;
    localparam int STAT_BUSY       = 3;

    localparam int CTRL_CLEAR       = 0;
    localparam int CTRL_RESET_INDEX = 1;
    localparam int CTRL_IRQ_MASK    = 2;

    typedef struct packed {
        logic abort;
        logic overrun;
        logic frame_done;
    } status_t;

    // Map layout: rx_buf at 0..N-1, status at N, tx_buf at N+1..2N, control at 2N+1
    function automatic int status_offset(input int buffer_size);
        return buffer_size;
    endfunction

    function automatic int tx_offset(input int buffer_size);
        return buffer_size + 1;
    endfunction

    function automatic int ctrl_offset(input int buffer_size);
        return 2 * buffer_size + 1;
    endfunction

endpackage

// File: rtl/spi_peripheral_shifter.sv
// SPI mode-0 byte shifter: input synchronizers, sclk edge detection and the
// IDLE/SHIFT/HOLD peripheral FSM. Moves one byte per select window, LSB first.
module spi_peripheral_shifter
    import spi_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sclk_in,
    input  logic                 slave_select_in,
    input  logic                 data_in,
    input  logic [BYTE_SIZE-1:0] tx_byte,
    output logic                 data_bit,
    output logic                 data_oe,
    output logic                 byte_done,
    output logic [BYTE_SIZE-1:0] rx_byte,
    output logic                 abort,
    output logic                 busy
);

    localparam int CNT_W = $clog2(BYTE_SIZE);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_SIZE - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic                 sclk_meta, sclk_sync, sclk_prev;
    logic                 ss_meta, ss_sync;
    logic                 din_meta, din_sync;
    logic                 sclk_rise, sclk_fall;
    logic [1:0]           state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [BYTE_SIZE-1:0] tx_shift;
    logic [BYTE_SIZE-1:0] rx_shift;

    // Select resets high so the output is released while reset is held
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            din_meta  <= 1'b0;
            din_sync  <= 1'b0;
        end else begin
            sclk_meta <= sclk_in;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            ss_meta   <= slave_select_in;
            ss_sync   <= ss_meta;
            din_meta  <= data_in;
            din_sync  <= din_meta;
        end
    end

    assign sclk_rise = sclk_sync & ~sclk_prev;
    assign sclk_fall = ~sclk_sync & sclk_prev;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            byte_done <= 1'b0;
            abort     <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            abort     <= 1'b0;
            case (state)
                IDLE: begin
                    if (!ss_sync) begin
                        state    <= SHIFT;
                        bit_cnt  <= '0;
                        tx_shift <= tx_byte;
                    end
                end
                SHIFT: begin
                    if (ss_sync) begin
                        state <= IDLE;
                        abort <= 1'b1;
                    end else if (sclk_rise) begin
                        rx_shift <= {din_sync, rx_shift[BYTE_SIZE-1:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            byte_done <= 1'b1;
                            state     <= HOLD;
                        end
                    end else if (sclk_fall) begin
                        tx_shift <= tx_shift >> 1;
                    end
                end
                HOLD: begin
                    if (ss_sync) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bit 0 is presented straight from tx_byte until the FSM latches it
    assign data_oe  = ~ss_sync;
    assign data_bit = (state == IDLE) ? tx_byte[0] : tx_shift[0];
    assign rx_byte  = rx_shift;
    assign busy     = (state != IDLE);

endmodule

// File: rtl/spi_peripheral.sv
// SPI peripheral with rx/tx byte buffers behind a Wishbone register window.
// Optional feature: define SPI_PERIPHERAL_IRQ_EN to add irq_o and the control irq mask bit.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int                    BUFFER_SIZE  = 16,
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = 'h0E00
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sclk_in,
    input  logic                  slave_select_in,
    input  logic                  data_in,
    output logic                  data_out,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  we_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] dat_o
`ifdef SPI_PERIPHERAL_IRQ_EN
    ,
    output logic                  irq_o
`endif
);

    localparam int IDX_W = $clog2(BUFFER_SIZE);
    localparam logic [ADDR_WIDTH-1:0] OFF_STATUS = ADDR_WIDTH'(status_offset(BUFFER_SIZE));
    localparam logic [ADDR_WIDTH-1:0] OFF_TX     = ADDR_WIDTH'(tx_offset(BUFFER_SIZE));
    localparam logic [ADDR_WIDTH-1:0] OFF_CTRL   = ADDR_WIDTH'(ctrl_offset(BUFFER_SIZE));
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(BUFFER_SIZE - 1);

    localparam logic [1:0] WB_WAIT     = 2'd0;
    localparam logic [1:0] WB_RESP     = 2'd1;
    localparam logic [1:0] WB_DEASSERT = 2'd2;

    logic [BYTE_SIZE-1:0]  tx_buf [BUFFER_SIZE];
    logic [BYTE_SIZE-1:0]  rx_buf [BUFFER_SIZE];
    logic [IDX_W-1:0]      byte_index;
    status_t               status;
    logic [1:0]            wb_state;

    logic                  busy, byte_done, abort_pulse, data_oe, data_bit;
    logic [BYTE_SIZE-1:0]  rx_byte;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  in_window, rd_hit, wr_hit, hit, req;
    logic                  wr_tx, wr_ctrl, host_clear, frame_set;
    logic [BYTE_SIZE-1:0]  rd_byte;
    logic                  unused_dat;

    spi_peripheral_shifter u_shifter (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .sclk_in         (sclk_in),
        .slave_select_in (slave_select_in),
        .data_in         (data_in),
        .tx_byte         (tx_buf[byte_index]),
        .data_bit        (data_bit),
        .data_oe         (data_oe),
        .byte_done       (byte_done),
        .rx_byte         (rx_byte),
        .abort           (abort_pulse),
        .busy            (busy)
    );

    assign data_out = data_oe ? data_bit : 1'bz;

    // Reads cover rx_buf plus status; writes cover tx_buf plus control
    assign offset    = adr_i - BASE_ADDRESS;
    assign in_window = (adr_i >= BASE_ADDRESS);
    assign rd_hit    = in_window && (offset <= OFF_STATUS);
    assign wr_hit    = in_window && (offset >= OFF_TX) && (offset <= OFF_CTRL);
    assign hit       = we_i ? wr_hit : rd_hit;
    assign req       = (wb_state == WB_WAIT) && cyc_i && stb_i;
    assign wr_tx     = req && we_i && wr_hit && (offset != OFF_CTRL);
    assign wr_ctrl   = req && we_i && wr_hit && (offset == OFF_CTRL);
    assign unused_dat = ^dat_i;

    always_comb begin
        rd_byte = '0;
        if (offset == OFF_STATUS) begin
            rd_byte[STAT_FRAME_DONE] = status.frame_done;
            rd_byte[STAT_OVERRUN]    = status.overrun;
            rd_byte[STAT_ABORT]      = status.abort;
            rd_byte[STAT_BUSY]       = busy;
        end else begin
            rd_byte = rx_buf[IDX_W'(offset)];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_state <= WB_WAIT;
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
            dat_o    <= '0;
        end else begin
            case (wb_state)
                WB_WAIT: begin
                    if (req) begin
                        ack_o    <= hit;
                        err_o    <= ~hit;
                        dat_o    <= (!we_i && hit) ? DATA_WIDTH'(rd_byte) : '0;
                        wb_state <= WB_RESP;
                    end
                end
                WB_RESP: begin
                    ack_o    <= 1'b0;
                    err_o    <= 1'b0;
                    wb_state <= WB_DEASSERT;
                end
                WB_DEASSERT: wb_state <= WB_WAIT;
                default:     wb_state <= WB_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                tx_buf[i] <= '0;
            end
        end else if (wr_tx) begin
            tx_buf[IDX_W'(offset - OFF_TX)] <= dat_i[BYTE_SIZE-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (byte_done) begin
            rx_buf[byte_index] <= rx_byte;
        end
    end

    assign host_clear = wr_ctrl && dat_i[CTRL_CLEAR];
    assign frame_set  = byte_done && (byte_index == LAST_IDX);

    // Hardware sets are OR-ed in after the host clear so they win a same-cycle race
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            byte_index <= '0;
            status     <= '0;
        end else begin
            if (byte_done) begin
                byte_index <= byte_index + 1'b1;
            end else if (wr_ctrl && dat_i[CTRL_RESET_INDEX] && !busy) begin
                byte_index <= '0;
            end
            status.frame_done <= frame_set | (status.frame_done & ~host_clear);
            status.overrun    <= (frame_set & status.frame_done) | (status.overrun & ~host_clear);
            status.abort      <= abort_pulse | (status.abort & ~host_clear);
        end
    end

`ifdef SPI_PERIPHERAL_IRQ_EN
    logic irq_mask;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            irq_mask <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_mask <= dat_i[CTRL_IRQ_MASK];
            end
            irq_o <= (status.frame_done | status.overrun) & ~irq_mask;
        end
    end
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: register-map vector table, directed SPI
// frame sequences and a randomized run against a buffer-level reference model.
module tb_spi_peripheral;

    localparam int          BS       = 16;
    localparam logic [15:0] BASE     = 16'h0E00;
    localparam logic [15:0] A_STATUS = BASE + 16'(BS);
    localparam logic [15:0] A_TX     = BASE + 16'(BS + 1);
    localparam logic [15:0] A_CTRL   = BASE + 16'(2 * BS + 1);

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        sclk_in = 1'b0;
    logic        slave_select_in = 1'b1;
    logic        data_in = 1'b0;
    wire         data_out;
    logic [15:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic        we_i = 1'b0;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        ack_o, err_o;
    logic [31:0] dat_o;
`ifdef SPI_PERIPHERAL_IRQ_EN
    logic        irq_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] m_tx [BS];
    logic [7:0] m_rx [BS];
    bit         m_valid [BS];
    int         m_idx;
    bit         m_fd, m_ov, m_ab;

    typedef struct {
        bit          we;
        logic [15:0] adr;
        logic [31:0] wdat;
        bit          exp_ack;
        bit          exp_err;
        bit          chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs [11];

    spi_peripheral dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .sclk_in         (sclk_in),
        .slave_select_in (slave_select_in),
        .data_in         (data_in),
        .data_out        (data_out),
        .adr_i           (adr_i),
        .dat_i           (dat_i),
        .we_i            (we_i),
        .cyc_i           (cyc_i),
        .stb_i           (stb_i),
        .ack_o           (ack_o),
        .err_o           (err_o),
        .dat_o           (dat_o)
`ifdef SPI_PERIPHERAL_IRQ_EN
        ,
        .irq_o           (irq_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [15:0] adr, input logic [31:0] wdat,
                                 output logic ack, output logic err, output logic [31:0] rdat,
                                 output logic late);
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wdat;
        @(posedge clk_i); #1;
        ack = ack_o; err = err_o; rdat = dat_o;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk_i); #1;
        late = ack_o | err_o;
        @(posedge clk_i); #1;
    endtask

    task automatic modelReset();
        for (int i = 0; i < BS; i++) begin
            m_tx[i] = 8'h00;
            m_rx[i] = 8'h00;
            m_valid[i] = 1'b0;
        end
        m_idx = 0; m_fd = 0; m_ov = 0; m_ab = 0;
    endtask

    task automatic hostWrite(input logic [15:0] adr, input logic [31:0] wdat);
        logic ack, err, late;
        logic [31:0] rdat;
        applyStimulus(1'b1, adr, wdat, ack, err, rdat, late);
        checkOutput("write ack", {31'b0, ack}, 32'd1);
        checkOutput("write ack single", {31'b0, late}, 32'd0);
    endtask

    task automatic hostRead(input logic [15:0] adr, output logic [31:0] rdat);
        logic ack, err, late;
        applyStimulus(1'b0, adr, 32'h0, ack, err, rdat, late);
        checkOutput("read ack", {31'b0, ack}, 32'd1);
        checkOutput("read ack single", {31'b0, late}, 32'd0);
    endtask

    task automatic hostTx(input int i, input logic [7:0] v);
        hostWrite(A_TX + 16'(i), {24'hABCDEF, v});
        m_tx[i] = v;
    endtask

    task automatic hostCtrl(input logic [7:0] v);
        hostWrite(A_CTRL, {24'h0, v});
        if (v[0]) begin
            m_fd = 0; m_ov = 0; m_ab = 0;
        end
        if (v[1]) m_idx = 0;
    endtask

    task automatic hostStatus(output logic [31:0] d);
        hostRead(A_STATUS, d);
        checkOutput("status", d, {29'b0, m_ab, m_ov, m_fd});
    endtask

    task automatic hostRx(input int i);
        logic [31:0] d;
        hostRead(BASE + 16'(i), d);
        if (m_valid[i]) checkOutput($sformatf("rx[%0d]", i), d, {24'b0, m_rx[i]});
    endtask

    task automatic spiXfer(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
        miso = 8'h00;
        @(negedge clk_i);
        slave_select_in = 1'b0;
        repeat (4) @(negedge clk_i);
        for (int b = 0; b < nbits; b++) begin
            data_in = mosi[b];
            repeat (4) @(negedge clk_i);
            miso[b] = data_out;
            sclk_in = 1'b1;
            repeat (4) @(negedge clk_i);
            sclk_in = 1'b0;
        end
        repeat (4) @(negedge clk_i);
        slave_select_in = 1'b1;
        repeat (6) @(negedge clk_i);
        checkOutput("released after deselect", {31'b0, dut.data_oe}, 32'd0);
    endtask

    task automatic spiFull(input logic [7:0] mosi, output logic [7:0] miso);
        logic [7:0] expected;
        expected = m_tx[m_idx];
        spiXfer(mosi, 8, miso);
        checkOutput("miso byte", {24'b0, miso}, {24'b0, expected});
        m_rx[m_idx] = mosi;
        m_valid[m_idx] = 1'b1;
        if (m_idx == BS - 1) begin
            if (m_fd) m_ov = 1;
            m_fd = 1;
        end
        m_idx = (m_idx + 1) % BS;
        checkOutput("byte_index", {28'b0, dut.byte_index}, m_idx);
    endtask

    task automatic spiPartial(input int n);
        logic [7:0] miso, mask;
        mask = 8'((1 << n) - 1);
        spiXfer(8'($urandom), n, miso);
        checkOutput("partial miso", {24'b0, miso}, {24'b0, m_tx[m_idx] & mask});
        m_ab = 1;
        checkOutput("byte_index after abort", {28'b0, dut.byte_index}, m_idx);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  miso;
        logic        ack, err, late;

        modelReset();
        repeat (3) @(negedge clk_i);
        checkOutput("reset ack", {31'b0, ack_o}, 32'd0);
        checkOutput("reset err", {31'b0, err_o}, 32'd0);
        checkOutput("reset dat_o", dat_o, 32'd0);
        checkOutput("reset released", {31'b0, dut.data_oe}, 32'd0);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // Register-map decode table
        vecs[0]  = '{0, A_STATUS,         32'h0,        1, 0, 1, 32'h0};
        vecs[1]  = '{0, A_TX,             32'h0,        0, 1, 0, 32'h0};
        vecs[2]  = '{0, BASE - 16'd1,     32'h0,        0, 1, 0, 32'h0};
        vecs[3]  = '{1, A_STATUS,         32'h0,        0, 1, 0, 32'h0};
        vecs[4]  = '{1, BASE,             32'h55,       0, 1, 0, 32'h0};
        vecs[5]  = '{1, A_TX,             32'h123456A5, 1, 0, 0, 32'h0};
        vecs[6]  = '{1, A_TX + 16'(BS-1), 32'h0000007E, 1, 0, 0, 32'h0};
        vecs[7]  = '{1, A_CTRL,           32'h0,        1, 0, 0, 32'h0};
        vecs[8]  = '{1, A_CTRL + 16'd1,   32'h0,        0, 1, 0, 32'h0};
        vecs[9]  = '{0, A_CTRL,           32'h0,        0, 1, 0, 32'h0};
        vecs[10] = '{0, 16'h0F00,         32'h0,        0, 1, 0, 32'h0};
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].we, vecs[i].adr, vecs[i].wdat, ack, err, d, late);
            checkOutput($sformatf("vec%0d ack", i), {31'b0, ack}, {31'b0, vecs[i].exp_ack});
            checkOutput($sformatf("vec%0d err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
            checkOutput($sformatf("vec%0d single", i), {31'b0, late}, 32'd0);
            if (vecs[i].chk_dat) checkOutput($sformatf("vec%0d dat", i), d, vecs[i].exp_dat);
            if (vecs[i].we && vecs[i].exp_ack && vecs[i].adr >= A_TX && vecs[i].adr < A_CTRL)
                m_tx[vecs[i].adr - A_TX] = vecs[i].wdat[7:0];
        end

        // Read of first tx address and write past control both error out
        applyStimulus(1'b0, A_TX, 32'h0, ack, err, d, late);
        checkOutput("rd tx err", {31'b0, err}, 32'd1);
        checkOutput("rd tx no ack", {31'b0, ack}, 32'd0);
        checkOutput("rd tx err single", {31'b0, late}, 32'd0);
        applyStimulus(1'b1, BASE + 16'(2 * BS + 2), 32'h1, ack, err, d, late);
        checkOutput("wr beyond ctrl err", {31'b0, err}, 32'd1);

        // Single byte exchange
        hostTx(0, 8'hA5);
        spiFull(8'h3C, miso);
        checkOutput("A5 lsb first", {24'b0, miso}, 32'hA5);
        hostRead(BASE, d);
        checkOutput("rx0 is 3C", d, 32'h3C);
        checkOutput("index is 1", {28'b0, dut.byte_index}, 32'd1);

        // One complete frame
        hostCtrl(8'h03);
        for (int i = 0; i < BS; i++) spiFull(8'($urandom), miso);
        hostStatus(d);
        checkOutput("frame status", d, 32'h01);
        checkOutput("frame index wrap", {28'b0, dut.byte_index}, 32'd0);
        hostCtrl(8'h01);
        hostStatus(d);
        checkOutput("cleared status", d, 32'h00);

        // Deselect after 5 bits
        hostRx(BS - 1);
        spiPartial(5);
        hostStatus(d);
        checkOutput("abort status", d, 32'h04);
        hostRx(0);
        hostCtrl(8'h01);

        // Two frames without clearing
        for (int i = 0; i < 2 * BS; i++) spiFull(8'($urandom), miso);
        hostStatus(d);
        checkOutput("overrun status", d, 32'h03);
`ifdef SPI_PERIPHERAL_IRQ_EN
        checkOutput("irq asserted", {31'b0, irq_o}, 32'd1);
`endif
        hostCtrl(8'h01);

        // Randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            int op;
            op = int'($urandom_range(0, 5));
            case (op)
                0: hostTx(int'($urandom_range(0, BS - 1)), 8'($urandom));
                1: spiFull(8'($urandom), miso);
                2: spiPartial(int'($urandom_range(1, 7)));
                3: hostRx(int'($urandom_range(0, BS - 1)));
                4: hostStatus(d);
                default: hostCtrl(8'($urandom_range(0, 3)));
            endcase
        end

        // Reset in the middle of a byte
        hostRead(A_STATUS, d);
        @(negedge clk_i);
        slave_select_in = 1'b0;
        repeat (4) @(negedge clk_i);
        for (int b = 0; b < 4; b++) begin
            data_in = b[0];
            repeat (4) @(negedge clk_i);
            sclk_in = 1'b1;
            repeat (4) @(negedge clk_i);
            sclk_in = 1'b0;
        end
        data_in = 1'b1;
        repeat (4) @(negedge clk_i);
        sclk_in = 1'b1;
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("midreset released", {31'b0, dut.data_oe}, 32'd0);
        checkOutput("midreset ack", {31'b0, ack_o}, 32'd0);
        checkOutput("midreset err", {31'b0, err_o}, 32'd0);
        checkOutput("midreset dat_o", dat_o, 32'd0);
        checkOutput("midreset index", {28'b0, dut.byte_index}, 32'd0);
        sclk_in = 1'b0;
        slave_select_in = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (4) @(negedge clk_i);
        modelReset();
        hostStatus(d);
        checkOutput("post reset status", d, 32'h00);
        spiFull(8'h5A, miso);
        hostRx(0);
        hostRead(BASE, d);
        checkOutput("post reset rx0", d, 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
